mul_seq_engine: RTL and testbench
=================================

MUL_SEQ_ENGINE -- requirements
Module: mul_seq_engine

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning input sample width in bits.
REQ-002 The block SHALL have parameter CW, default 4, meaning unsigned coefficient width in bits.
REQ-003 The block SHALL have parameter NCOEF, default 4, meaning coefficient table depth (2..16).
REQ-004 The block SHALL have derived parameters OW = DW+CW (product width) and IW = $clog2(NCOEF) (index width).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state rises on posedge clk.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is offered.
REQ-008 The block SHALL have port in_data, input, DW bits: unsigned sample.
REQ-009 The block SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data, out_idx and out_last hold a product.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream consumes the product.
REQ-012 The block SHALL have port out_data, output, OW bits: sample * coef[out_idx].
REQ-013 The block SHALL have port out_idx, output, IW bits: coefficient index of the current product.
REQ-014 The block SHALL have port out_last, output, 1 bit: current product is the final one for the sample.
REQ-015 The block SHALL have port cfg_we, input, 1 bit: coefficient write strobe.
REQ-016 The block SHALL have port cfg_addr, input, IW bits: coefficient write index.
REQ-017 The block SHALL have port cfg_data, input, CW bits: coefficient write value.
REQ-018 The block SHALL have port cfg_len, input, IW+1 bits: active sequence length L, sampled at accept.

Function
REQ-019 The FSM SHALL have states IDLE and RUN; IDLE -> RUN on accept; RUN -> IDLE on consume of the last product with no new accept.
REQ-020 Accept SHALL be in_valid && in_ready; consume SHALL be out_valid && out_ready.
REQ-021 in_ready SHALL equal (state==IDLE) || (consume && out_last), allowing back-to-back samples with zero bubbles.
REQ-022 On accept, the block SHALL latch in_data and L; the product for index 0 SHALL be valid on the next cycle (latency 1).
REQ-023 Each consume with out_last=0 SHALL advance out_idx by 1 and present the next product on the next cycle.
REQ-024 out_last SHALL be 1 iff out_idx == L-1; L equal to 0 or greater than NCOEF SHALL be treated as NCOEF.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-026 Products SHALL be unsigned, computed full-width at OW bits with no truncation; the maximum value SHALL be (2^DW-1)*(2^CW-1).
REQ-027 A cfg_we in IDLE, or in the same cycle as a final consume, SHALL update coef[cfg_addr] from the next cycle; a cfg_we during RUN SHALL be ignored otherwise.
REQ-028 cfg_addr >= NCOEF SHALL be ignored.

Reset
REQ-029 rst low SHALL immediately force IDLE, in_ready=0 during reset, and out_valid=0, out_data=0, out_idx=0, out_last=0; coefficient registers SHALL return to defaults {1,3,7,8}, with index i >= 4 defaulting to i+1.
REQ-030 Reset mid-sequence SHALL abandon the sample; after release, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-031 Macro MUL_SEQ_CFG_EN, when defined, SHALL enable the runtime coefficient write port (REQ-027).
REQ-032 Without MUL_SEQ_CFG_EN, cfg_we, cfg_addr and cfg_data SHALL be ignored and the coefficients SHALL be the reset defaults, held constant.

Structure
REQ-033 Package mul_seq_pkg SHALL hold the state enum (IDLE, RUN) and the default coefficient function/constant.
REQ-034 The coefficient table SHALL be a sub-module mul_seq_coef_rf (NCOEF x CW registers, one write port, one async read port).

Verification
REQ-035 Default coefficients, in_data=8'd10, L=4, out_ready=1 SHALL produce out_data 10, 30, 70, 80 on consecutive cycles, with out_last on 80.
REQ-036 Back-to-back samples 5 then 255, L=4, out_ready=1 SHALL produce 5, 15, 35, 40, 255, 765, 1785, 2040 with no gap, and in_ready high on the 40 cycle.
REQ-037 out_ready toggled 1,0,0,1 during sample 9 SHALL hold 27 stable for 3 cycles, then produce 63.
REQ-038 With MUL_SEQ_CFG_EN, writing coef[1]=15 in IDLE, then in_data=255, L=2 SHALL produce 255 then 3825 (out_last), and a cfg_we during RUN SHALL change nothing.
REQ-039 rst asserted after the product 30 of sample 10 SHALL drive all outputs to 0 immediately; after release in_ready=1 and a new sample starts at index 0.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and reset coefficient table for the sequential multiplier engine.
package mul_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Reset value of coefficient i: {1,3,7,8} for the first four, i+1 beyond.
  function automatic int coef_default(input int i);
    case (i)
      0:       coef_default = 1;
      1:       coef_default = 3;
      2:       coef_default = 7;
      3:       coef_default = 8;
      default: coef_default = i + 1;
    endcase
  endfunction

endpackage

// File: rtl/mul_seq_engine_if.sv
// Sample-in / product-out handshake plus coefficient config bus for mul_seq_engine.
interface mul_seq_engine_if #(
  parameter int DW    = 8,
  parameter int CW    = 4,
  parameter int NCOEF = 4
);
  localparam int OW = DW + CW;
  localparam int IW = $clog2(NCOEF);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          cfg_we;
  logic [IW-1:0] cfg_addr;
  logic [CW-1:0] cfg_data;
  logic [IW:0]   cfg_len;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data, cfg_len,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data, cfg_len,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/mul_seq_coef_rf.sv
// Coefficient register file: NCOEF x CW flops, one write port, one async read port.
module mul_seq_coef_rf
  import mul_seq_pkg::*;
#(
  parameter  int NCOEF = 4,
  parameter  int CW    = 4,
  localparam int IW    = $clog2(NCOEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic [IW-1:0] rd_addr,
  output logic [CW-1:0] rd_data
);

  logic [CW-1:0] coef_q [NCOEF];
  logic [CW-1:0] coef_d [NCOEF];

  // Addresses at or above NCOEF match no entry, so such writes fall away.
  always_comb begin
    for (int i = 0; i < NCOEF; i++) begin
      if (wr_en && (wr_addr == IW'(i))) begin
        coef_d[i] = wr_data;
      end else begin
        coef_d[i] = coef_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCOEF; i++) begin
        coef_q[i] <= CW'(coef_default(i));
      end
    end else begin
      coef_q <= coef_d;
    end
  end

  always_comb begin
    if (int'(rd_addr) < NCOEF) begin
      rd_data = coef_q[rd_addr];
    end else begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/mul_seq_engine.sv
// Multiplies each accepted sample by coef[0..L-1] in turn, one product per consume.
// Define MUL_SEQ_CFG_EN to enable runtime coefficient writes; otherwise coefficients are fixed.
module mul_seq_engine
  import mul_seq_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int CW    = 4,
  parameter  int NCOEF = 4,
  localparam int OW    = DW + CW,
  localparam int IW    = $clog2(NCOEF)
) (
  input logic             clk,
  input logic             rst,
  mul_seq_engine_if.slave bus
);

  localparam logic [IW:0] LEN_MAX = (IW+1)'(NCOEF);

  state_e        state_q, state_d;
  logic [DW-1:0] sample_q, sample_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_idx_q, last_idx_d;
  logic [IW:0]   len_eff_s;
  logic [IW-1:0] len_m1_s;
  logic [CW-1:0] coef_s;
  logic          out_valid_s, last_s, consume_s, final_s;
  logic          in_ready_s, accept_s, coef_we_s;

  // in_ready is gated by rst so it reads 0 throughout reset, 1 right after release.
  always_comb begin
    out_valid_s = (state_q == RUN);
    last_s      = (idx_q == last_idx_q);
    consume_s   = out_valid_s && bus.out_ready;
    final_s     = consume_s && last_s;
    in_ready_s  = rst && ((state_q == IDLE) || final_s);
    accept_s    = bus.in_valid && in_ready_s;
  end

  always_comb begin
    if ((bus.cfg_len == '0) || (bus.cfg_len > LEN_MAX)) begin
      len_eff_s = LEN_MAX;
    end else begin
      len_eff_s = bus.cfg_len;
    end
    len_m1_s = IW'(len_eff_s - (IW+1)'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = RUN;
        else          state_d = IDLE;
      end
      RUN: begin
        if (final_s && !accept_s) state_d = IDLE;
        else                      state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // An accept on the final consume restarts at index 0 with no bubble.
  always_comb begin
    sample_d   = sample_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    if (accept_s) begin
      sample_d   = bus.in_data;
      idx_d      = '0;
      last_idx_d = len_m1_s;
    end else if (consume_s && !last_s) begin
      idx_d = idx_q + IW'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_q   <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
    end else begin
      sample_q   <= sample_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
    end
  end

`ifdef MUL_SEQ_CFG_EN
  // Writes only land between sequences so a running sample sees a stable table.
  always_comb begin
    coef_we_s = bus.cfg_we && ((state_q == IDLE) || final_s);
  end
`else
  logic unused_cfg_we_s;
  always_comb begin
    coef_we_s       = 1'b0;
    unused_cfg_we_s = bus.cfg_we;
  end
`endif

  mul_seq_coef_rf #(
    .NCOEF (NCOEF),
    .CW    (CW)
  ) u_coef_rf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (coef_we_s),
    .wr_addr (bus.cfg_addr),
    .wr_data (bus.cfg_data),
    .rd_addr (idx_q),
    .rd_data (coef_s)
  );

  always_comb begin
    bus.in_ready  = in_ready_s;
    bus.out_valid = out_valid_s;
    bus.out_idx   = idx_q;
    bus.out_last  = out_valid_s && last_s;
    bus.out_data  = OW'(sample_q) * OW'(coef_s);
  end

endmodule

// File: tb/tb_mul_seq_engine.sv
// Directed scoreboard bench for mul_seq_engine; products are checked as they are consumed.
module tb_mul_seq_engine;

  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int NCOEF = 4;
  localparam int OW    = DW + CW;
  localparam int IW    = 2;

`ifdef MUL_SEQ_CFG_EN
  localparam int COEF1_AFTER = 15;
`else
  localparam int COEF1_AFTER = 3;
`endif

  typedef struct packed {
    logic [OW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  mul_seq_engine_if #(.DW(DW), .CW(CW), .NCOEF(NCOEF)) bus ();

  mul_seq_engine #(.DW(DW), .CW(CW), .NCOEF(NCOEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int d, input int i, input bit l);
    exp_t t;
    t.data = OW'(d);
    t.idx  = IW'(i);
    t.last = l;
    sb.push_back(t);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input int l);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(d);
    bus.cfg_len  = 3'(l);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid !== 1'b0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_idle", bus.out_valid, 0);
  endtask

  // Scoreboard: every consumed product must match the head of the queue.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_product", bus.out_data, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", bus.out_data, mon_e.data);
        chk("out_idx", bus.out_idx, mon_e.idx);
        chk("out_last", bus.out_last, mon_e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.cfg_len  = '0;

    #3;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_last", bus.out_last, 0);
    sync();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Single sample 10 with default coefficients
    sync();
    push(10, 0, 0); push(30, 1, 0); push(70, 2, 0); push(80, 3, 1);
    send(10, 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("seq10_valid", bus.out_valid, 1);
    end
    drain();

    // Back-to-back 5 then 255 with in_valid held high
    sync();
    push(5, 0, 0); push(15, 1, 0); push(35, 2, 0); push(40, 3, 1);
    push(255, 0, 0); push(765, 1, 0); push(1785, 2, 0); push(2040, 3, 1);
    bus.in_valid = 1'b1; bus.in_data = 8'd5; bus.cfg_len = 3'd4;
    sync();
    bus.in_data = 8'd255;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b2b_valid", bus.out_valid, 1);
      if (k < 3) begin
        chk("b2b_in_ready_low", bus.in_ready, 0);
      end else if (k == 3) begin
        chk("b2b_in_ready_on_last", bus.in_ready, 1);
        sync();
        bus.in_valid = 1'b0;
      end else begin
        chk("b2b_in_ready_run", bus.in_ready, (k == 7) ? 1 : 0);
      end
    end
    drain();

    // Length boundaries: 1, 0 (full table), 5 and 7 (both clipped to 4)
    sync();
    push(3, 0, 1);
    send(3, 1);
    drain();
    sync();
    push(200, 0, 0); push(600, 1, 0); push(1400, 2, 0); push(1600, 3, 1);
    send(200, 0);
    drain();
    sync();
    push(255, 0, 0); push(765, 1, 0); push(1785, 2, 0); push(2040, 3, 1);
    send(255, 7);
    drain();
    sync();
    push(17, 0, 0); push(51, 1, 0); push(119, 2, 0); push(136, 3, 1);
    send(17, 5);
    drain();

    // Backpressure: out_ready 1,0,0,1 holds 27
    sync();
    push(9, 0, 0); push(27, 1, 0); push(63, 2, 0); push(72, 3, 1);
    send(9, 4);
    @(negedge clk);
    sync();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_data", bus.out_data, 27);
      chk("hold_idx", bus.out_idx, 1);
      chk("hold_last", bus.out_last, 0);
      if (k == 1) begin
        sync();
        bus.out_ready = 1'b1;
      end
    end
    drain();

    // Coefficient write in IDLE, then an ignored write while running
    sync();
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_data = 4'd15;
    sync();
    bus.cfg_we = 1'b0;
    push(255, 0, 0); push(255 * COEF1_AFTER, 1, 1);
    bus.in_valid = 1'b1; bus.in_data = 8'd255; bus.cfg_len = 3'd2;
    sync();
    bus.in_valid = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_data = 4'd2;
    sync();
    bus.cfg_we = 1'b0;
    drain();
    sync();
    push(1, 0, 0); push(COEF1_AFTER, 1, 1);
    send(1, 2);
    drain();

    // Reset after product 30 of sample 10
    sync();
    push(10, 0, 0); push(30, 1, 0);
    send(10, 4);
    @(negedge clk);
    @(negedge clk);
    sync();
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_out_idx", bus.out_idx, 0);
    chk("midrst_out_last", bus.out_last, 0);
    sync();
    rst = 1'b1;
    @(negedge clk);
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_out_valid", bus.out_valid, 0);
    push(4, 0, 0); push(12, 1, 1);
    bus.in_valid = 1'b1; bus.in_data = 8'd4; bus.cfg_len = 3'd2;
    sync();
    bus.in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
